// File: rtl/arbitro_acciones.sv
// -----------------------------------------------------------------------------
// arbitro_acciones
//
// Arbitration and sequencing stage between the debounced input block and the
// pet state machine. Every level change on one of the four toggle-style action
// inputs becomes one pending request. Pending requests are offered one at a
// time to the pet FSM over a valid/ready handshake. An offer that is not taken
// within TIMEOUT cycles is dropped and counted. In normal mode a cooldown
// follows every grant or drop. In test mode the policy becomes fixed priority
// with no cooldown.
//
// Parameters
//   TIMEOUT   (>=1) max cycles accion_valid stays high without accion_ready
//   COOLDOWN  (>=0) idle cycles after each grant/drop in normal mode
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   asynchronous, active-low; clears all state
//   senal_energia      in   debounced toggle, source 0
//   senal_medicina     in   debounced toggle, source 1
//   senal_ultrasonido  in   debounced toggle, source 2
//   senal_fot          in   debounced toggle, source 3
//   senal_test         in   test-mode level (1 = test mode)
//   accion_ready       in   pet FSM accepts the offered action
//   accion_valid       out  an action is being offered
//   accion_id    [1:0] out  source index of the offered action
//   pendientes   [3:0] out  pending-request bitmap, bit i = source i
//   modo_test          out  registered copy of senal_test
//   descartes    [7:0] out  timed-out request count, saturates at 255
// -----------------------------------------------------------------------------
module arbitro_acciones #(
  parameter int TIMEOUT  = 16,
  parameter int COOLDOWN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       senal_energia,
  input  logic       senal_medicina,
  input  logic       senal_ultrasonido,
  input  logic       senal_fot,
  input  logic       senal_test,
  input  logic       accion_ready,
  output logic       accion_valid,
  output logic [1:0] accion_id,
  output logic [3:0] pendientes,
  output logic       modo_test,
  output logic [7:0] descartes
);

  // ---------------------------------------------------------------------------
  // FSM encoding and counter sizing
  // ---------------------------------------------------------------------------
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OFRECER = 2'd1;
  localparam logic [1:0] ESPERA  = 2'd2;

  localparam int TW = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  // Last timer value before a drop, last cooldown count before leaving ESPERA.
  localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] COOL_LAST    = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam bit            HAS_COOLDOWN = (COOLDOWN > 0);

  // ---------------------------------------------------------------------------
  // Selection helpers
  // ---------------------------------------------------------------------------

  // Fixed priority: lowest set index wins.
  function automatic logic [1:0] pick_fixed(input logic [3:0] req);
    logic [1:0] pick;
    pick = 2'd0;
    // Walking downwards lets the lowest set index overwrite the others.
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) pick = 2'(k);
    end
    return pick;
  endfunction

  // Round-robin: first set index at or after ptr, wrapping modulo 4.
  function automatic logic [1:0] pick_rr(input logic [3:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    // Smallest offset from ptr wins; the 2-bit add wraps naturally.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]    entradas;
  logic [3:0]    prev;
  logic          primo;
  logic [3:0]    toggles;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [CW-1:0] cool;
  logic [1:0]    rr_ptr;

  logic [1:0]    state_d;
  logic [1:0]    id_d;
  logic [TW-1:0] timer_d;
  logic [CW-1:0] cool_d;
  logic [1:0]    rr_ptr_d;
  logic [7:0]    descartes_d;
  logic [3:0]    clr;
  logic [3:0]    pend_d;
  logic [1:0]    sel;
  logic          fin;

  assign entradas = {senal_fot, senal_ultrasonido, senal_medicina, senal_energia};

  // The first edge after reset only captures the input levels, so whatever
  // the switches happen to show at power-up is never mistaken for a request.
  assign toggles = primo ? 4'b0000 : (entradas ^ prev);

  assign sel = modo_test ? pick_fixed(pendientes) : pick_rr(pendientes, rr_ptr);

  // Set wins over clear: a toggle arriving on the accept/drop edge of the
  // same source is a fresh request and must survive.
  assign pend_d = (pendientes & ~clr) | toggles;

  assign accion_valid = (state == OFRECER);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state;
    id_d        = accion_id;
    timer_d     = timer;
    cool_d      = cool;
    rr_ptr_d    = rr_ptr;
    descartes_d = descartes;
    clr         = 4'b0000;
    fin         = 1'b0;

    case (state)
      IDLE: begin
        if (|pendientes) begin
          id_d    = sel;
          timer_d = '0;
          state_d = OFRECER;
        end
      end

      OFRECER: begin
        // Accept is tested first so it wins over a timeout on the same edge.
        if (accion_ready) begin
          clr[accion_id] = 1'b1;
          fin            = 1'b1;
        end else if (timer == TIMER_LAST) begin
          clr[accion_id] = 1'b1;
          fin            = 1'b1;
          if (descartes != 8'hFF) descartes_d = descartes + 8'd1;
        end else begin
          timer_d = timer + TW'(1);
        end

        if (fin) begin
          // Test mode is fixed priority, so the pointer is left untouched.
          if (!modo_test) rr_ptr_d = accion_id + 2'd1;
          if (modo_test || !HAS_COOLDOWN) begin
            state_d = IDLE;
          end else begin
            state_d = ESPERA;
            cool_d  = '0;
          end
        end
      end

      ESPERA: begin
        if (cool == COOL_LAST) state_d = IDLE;
        else                   cool_d  = cool + CW'(1);
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the reset branch is asynchronous, so pulling reset low mid-offer
  // drops accion_valid at once without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev       <= 4'b0000;
      primo      <= 1'b1;
      pendientes <= 4'b0000;
      state      <= IDLE;
      accion_id  <= 2'd0;
      timer      <= '0;
      cool       <= '0;
      rr_ptr     <= 2'd0;
      modo_test  <= 1'b0;
      descartes  <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // values from before this edge, independent of statement order.
      prev       <= entradas;
      primo      <= 1'b0;
      pendientes <= pend_d;
      state      <= state_d;
      accion_id  <= id_d;
      timer      <= timer_d;
      cool       <= cool_d;
      rr_ptr     <= rr_ptr_d;
      modo_test  <= senal_test;
      descartes  <= descartes_d;
    end
  end

endmodule

// File: tb/tb_arbitro_acciones.sv
// -----------------------------------------------------------------------------
// tb_arbitro_acciones
//
// Bench for arbitro_acciones with default parameters (TIMEOUT=16, COOLDOWN=4).
// A table of per-cycle records {reset, inputs, expected outputs} covers reset,
// prime, single grant with cooldown, round-robin over four sources, test-mode
// fixed priority, request merging and a toggle on the accept edge. Hand-written
// sequences cover the timeout length, accept beating timeout, saturation of
// the drop counter and reset in the middle of an offer.
//
// Inputs are driven on the falling edge, outputs are sampled on the next
// falling edge after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_arbitro_acciones;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sig = 4'b0000;   // {fot, ultrasonido, medicina, energia}
  logic       test = 1'b0;
  logic       ready = 1'b0;

  logic       accion_valid;
  logic [1:0] accion_id;
  logic [3:0] pendientes;
  logic       modo_test;
  logic [7:0] descartes;

  int checks = 0;
  int errors = 0;

  arbitro_acciones #(.TIMEOUT(16), .COOLDOWN(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .senal_energia     (sig[0]),
    .senal_medicina    (sig[1]),
    .senal_ultrasonido (sig[2]),
    .senal_fot         (sig[3]),
    .senal_test        (test),
    .accion_ready      (ready),
    .accion_valid      (accion_valid),
    .accion_id         (accion_id),
    .pendientes        (pendientes),
    .modo_test         (modo_test),
    .descartes         (descartes)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst_n;
    logic [3:0] sig;
    logic       test;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_pend;
    logic       exp_mode;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst_n, input logic [3:0] s,
                              input logic t, input logic r,
                              input logic ev, input logic [1:0] eid,
                              input logic [3:0] ep, input logic em);
    vec_t v;
    v.rst_n = rst_n; v.sig = s; v.test = t; v.ready = r;
    v.exp_valid = ev; v.exp_id = eid; v.exp_pend = ep; v.exp_mode = em;
    vecs.push_back(v);
  endfunction

  function automatic void rep(input int n, input logic [3:0] s,
                              input logic t, input logic r,
                              input logic ev, input logic [1:0] eid,
                              input logic [3:0] ep, input logic em);
    for (int k = 0; k < n; k++) add(1'b1, s, t, r, ev, eid, ep, em);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; sig = 4'b0000; test = 1'b0; ready = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);  // prime edge
  endtask

  int cnt;
  int wait_fail;

  initial begin
    // ---- Scenario A: reset/prime with medicina high, single grant, cooldown
    add(0, 4'b0010, 0, 1, 0, 2'd0, 4'b0000, 0);  // in reset
    add(1, 4'b0010, 0, 1, 0, 2'd0, 4'b0000, 0);  // prime: no request
    add(1, 4'b0010, 0, 1, 0, 2'd0, 4'b0000, 0);
    add(1, 4'b0011, 0, 1, 0, 2'd0, 4'b0001, 0);  // energia toggles, edge k
    add(1, 4'b0011, 0, 1, 1, 2'd0, 4'b0001, 0);  // offer after k+1
    add(1, 4'b0011, 0, 1, 0, 2'd0, 4'b0000, 0);  // accepted k+2
    add(1, 4'b0001, 0, 1, 0, 2'd0, 4'b0010, 0);  // medicina toggles in cooldown
    rep(3, 4'b0001, 0, 1, 0, 2'd0, 4'b0010, 0);  // rest of cooldown, idle
    add(1, 4'b0001, 0, 1, 1, 2'd1, 4'b0010, 0);  // offer 6 edges after first accept edge-1
    add(1, 4'b0001, 0, 1, 0, 2'd1, 4'b0000, 0);
    rep(4, 4'b0001, 0, 1, 0, 2'd1, 4'b0000, 0);

    // ---- Scenario B: all four toggle together, round-robin order 0,1,2,3
    add(0, 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0);
    add(1, 4'b0000, 0, 1, 0, 2'd0, 4'b0000, 0);  // prime
    add(1, 4'b1111, 0, 1, 0, 2'd0, 4'b1111, 0);
    add(1, 4'b1111, 0, 1, 1, 2'd0, 4'b1111, 0);
    add(1, 4'b1111, 0, 1, 0, 2'd0, 4'b1110, 0);
    rep(4, 4'b1111, 0, 1, 0, 2'd0, 4'b1110, 0);
    add(1, 4'b1111, 0, 1, 1, 2'd1, 4'b1110, 0);
    add(1, 4'b1111, 0, 1, 0, 2'd1, 4'b1100, 0);
    rep(4, 4'b1111, 0, 1, 0, 2'd1, 4'b1100, 0);
    add(1, 4'b1111, 0, 1, 1, 2'd2, 4'b1100, 0);
    add(1, 4'b1111, 0, 1, 0, 2'd2, 4'b1000, 0);
    rep(4, 4'b1111, 0, 1, 0, 2'd2, 4'b1000, 0);
    add(1, 4'b1111, 0, 1, 1, 2'd3, 4'b1000, 0);
    add(1, 4'b1111, 0, 1, 0, 2'd3, 4'b0000, 0);  // pointer wraps to 0
    add(1, 4'b0110, 0, 1, 0, 2'd3, 4'b1001, 0);  // sources 0 and 3 toggle
    rep(3, 4'b0110, 0, 1, 0, 2'd3, 4'b1001, 0);
    add(1, 4'b0110, 0, 1, 1, 2'd0, 4'b1001, 0);  // 0 before 3
    add(1, 4'b0110, 0, 1, 0, 2'd0, 4'b1000, 0);
    rep(4, 4'b0110, 0, 1, 0, 2'd0, 4'b1000, 0);
    add(1, 4'b0110, 0, 1, 1, 2'd3, 4'b1000, 0);
    add(1, 4'b0110, 0, 1, 0, 2'd3, 4'b0000, 0);

    // ---- Scenario C: test mode, pending 1100, source 0 arrives mid-offer
    add(0, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 0);
    add(1, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 1);  // prime
    add(1, 4'b1100, 1, 0, 0, 2'd0, 4'b1100, 1);
    add(1, 4'b1100, 1, 0, 1, 2'd2, 4'b1100, 1);
    add(1, 4'b1101, 1, 0, 1, 2'd2, 4'b1101, 1);  // id held during offer
    add(1, 4'b1101, 1, 1, 0, 2'd2, 4'b1001, 1);  // grant 2
    add(1, 4'b1101, 1, 1, 1, 2'd0, 4'b1001, 1);
    add(1, 4'b1101, 1, 1, 0, 2'd0, 4'b1000, 1);  // grant 0, 2 cycles later
    add(1, 4'b1101, 1, 1, 1, 2'd3, 4'b1000, 1);
    add(1, 4'b1101, 1, 1, 0, 2'd3, 4'b0000, 1);  // grant 3

    // ---- Scenario D: merge of a double toggle, toggle on the accept edge
    add(0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0);
    add(1, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0);  // prime
    add(1, 4'b0100, 0, 0, 0, 2'd0, 4'b0100, 0);
    add(1, 4'b0000, 0, 0, 1, 2'd2, 4'b0100, 0);  // second toggle merges
    add(1, 4'b0000, 0, 1, 0, 2'd2, 4'b0000, 0);  // single grant
    rep(5, 4'b0000, 0, 1, 0, 2'd2, 4'b0000, 0);  // nothing follows
    add(1, 4'b0100, 0, 0, 0, 2'd2, 4'b0100, 0);
    add(1, 4'b0100, 0, 0, 1, 2'd2, 4'b0100, 0);
    add(1, 4'b0000, 0, 1, 0, 2'd2, 4'b0100, 0);  // accept + toggle: set wins
    rep(4, 4'b0000, 0, 1, 0, 2'd2, 4'b0100, 0);
    add(1, 4'b0000, 0, 1, 1, 2'd2, 4'b0100, 0);  // second grant
    add(1, 4'b0000, 0, 1, 0, 2'd2, 4'b0000, 0);

    // Start at a falling edge with reset asserted.
    @(negedge clk);
    check("reset_valid",     accion_valid, 1'b0);
    check("reset_descartes", descartes,    8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst_n;
      sig   = vecs[i].sig;
      test  = vecs[i].test;
      ready = vecs[i].ready;
      step(1);
      check($sformatf("vec%0d_valid", i), accion_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_id",    i), accion_id,    vecs[i].exp_id);
      check($sformatf("vec%0d_pend",  i), pendientes,   vecs[i].exp_pend);
      check($sformatf("vec%0d_mode",  i), modo_test,    vecs[i].exp_mode);
    end

    // ---- Timeout: valid high exactly 16 cycles, then bit cleared, 1 drop
    do_reset();
    sig[1] = 1'b1;
    step(1);
    check("to_pend_set", pendientes, 4'b0010);
    step(1);
    cnt = 0;
    while (accion_valid === 1'b1 && cnt < 100) begin
      cnt++;
      step(1);
    end
    check("to_valid_cycles", cnt,        16);
    check("to_pend_clear",   pendientes, 4'b0000);
    check("to_descartes",    descartes,  8'd1);

    // ---- Accept on the cycle a timeout would fire: accept wins
    step(5);
    sig[1] = 1'b0;
    step(2);
    check("atw_offer", accion_valid, 1'b1);
    step(15);
    check("atw_still_valid", accion_valid, 1'b1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("atw_valid_low",  accion_valid, 1'b0);
    check("atw_pend_clear", pendientes,   4'b0000);
    check("atw_descartes",  descartes,    8'd1);

    // ---- Saturation: drops 2..300
    wait_fail = 0;
    for (int d = 2; d <= 300; d++) begin
      sig[0] = ~sig[0];
      cnt = 0;
      while (accion_valid !== 1'b1 && cnt < 40) begin cnt++; step(1); end
      if (cnt >= 40) wait_fail++;
      cnt = 0;
      while (accion_valid !== 1'b0 && cnt < 40) begin cnt++; step(1); end
      if (cnt >= 40) wait_fail++;
      if (d == 254) check("sat_254", descartes, 8'd254);
      if (d == 255) check("sat_255", descartes, 8'd255);
    end
    check("sat_waits", wait_fail, 0);
    check("sat_300",   descartes, 8'd255);

    // ---- Reset in the middle of an offer
    step(6);
    sig[2] = ~sig[2];
    step(2);
    check("mid_offer_valid", accion_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid",     accion_valid, 1'b0);
    check("mid_rst_pend",      pendientes,   4'b0000);
    check("mid_rst_descartes", descartes,    8'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1);  // prime
    check("mid_prime_pend", pendientes, 4'b0000);
    sig[3] = ~sig[3];
    step(1);
    check("mid_new_pend", pendientes, 4'b1000);
    step(1);
    check("mid_new_valid", accion_valid, 1'b1);
    check("mid_new_id",    accion_id,    2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
